// File: rtl/spi_xfer_engine.sv
// SPI master transfer engine: one word per start, SPI modes 0-3, MSB/LSB first.
// Build option SPI_XFER_LOOPBACK_EN adds lpbk_i (receive from internal mosi).
module spi_xfer_engine #(
  parameter  int DATA_WIDTH = 32,
  parameter  int CS_NUM     = 4,
  parameter  int DIV_WIDTH  = 16,
  localparam int LW         = $clog2(DATA_WIDTH),
  localparam int CW         = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_i,
  input  logic [LW-1:0]         len_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [CW-1:0]         cs_sel_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
`ifdef SPI_XFER_LOOPBACK_EN
  input  logic                  lpbk_i,
`endif
  input  logic                  miso_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sck_o,
  output logic                  mosi_o,
  output logic [CS_NUM-1:0]     cs_n_o
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LW+1:0]         edg_q, edg_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic [LW-1:0]         len_q, len_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [CW-1:0]         cs_sel_q, cs_sel_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rxsh_q, rxsh_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  done_q, done_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
`ifdef SPI_XFER_LOOPBACK_EN
  logic                  lpbk_q, lpbk_d;
`endif

  logic                  busy;
  logic                  tick;
  logic                  last;
  logic [LW:0]           nbit;
  logic [LW:0]           b_idx;
  logic [LW:0]           drv_idx;
  logic                  leading;
  logic                  smp_edge;
  logic                  drv_ok;
  logic [LW-1:0]         smp_pos;
  logic [LW-1:0]         drv_pos;
  logic [LW-1:0]         first_pos;
  logic                  miso_s;

  // Edge k of 2N: even = leading, odd = trailing; bit index is k/2.
  always_comb begin
    busy      = (state_q != IDLE);
    tick      = (cnt_q == div_q);
    nbit      = {1'b0, len_q} + (LW+1)'(1);
    last      = (edg_q == {nbit, 1'b0});
    b_idx     = edg_q[LW+1:1];
    leading   = ~edg_q[0];
    smp_edge  = cpha_q ? ~leading : leading;
    drv_idx   = cpha_q ? b_idx : b_idx + (LW+1)'(1);
    drv_ok    = (drv_idx <= {1'b0, len_q});
    smp_pos   = lsb_q ? b_idx[LW-1:0] : len_q - b_idx[LW-1:0];
    drv_pos   = lsb_q ? drv_idx[LW-1:0] : len_q - drv_idx[LW-1:0];
    first_pos = lsb_i ? '0 : len_i;
`ifdef SPI_XFER_LOOPBACK_EN
    miso_s    = lpbk_q ? mosi_q : miso_i;
`else
    miso_s    = miso_i;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      edg_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      len_q    <= '0;
      div_q    <= '0;
      cs_sel_q <= '0;
      tx_q     <= '0;
      rxsh_q   <= '0;
      rx_q     <= '0;
      done_q   <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
`ifdef SPI_XFER_LOOPBACK_EN
      lpbk_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edg_q    <= edg_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      lsb_q    <= lsb_d;
      len_q    <= len_d;
      div_q    <= div_d;
      cs_sel_q <= cs_sel_d;
      tx_q     <= tx_d;
      rxsh_q   <= rxsh_d;
      rx_q     <= rx_d;
      done_q   <= done_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
`ifdef SPI_XFER_LOOPBACK_EN
      lpbk_q   <= lpbk_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && last) state_d = HOLD;
      HOLD:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && busy) state_d = IDLE;
  end

  always_comb begin
    cnt_d    = cnt_q;
    edg_d    = edg_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    lsb_d    = lsb_q;
    len_d    = len_q;
    div_d    = div_q;
    cs_sel_d = cs_sel_q;
    tx_d     = tx_q;
    rxsh_d   = rxsh_q;
    rx_d     = rx_q;
    done_d   = 1'b0;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
`ifdef SPI_XFER_LOOPBACK_EN
    lpbk_d   = lpbk_q;
`endif
    unique case (state_q)
      IDLE: begin
        sck_d  = cpol_i;
        mosi_d = 1'b0;
        cnt_d  = '0;
        if (start_i) begin
          cpol_d   = cpol_i;
          cpha_d   = cpha_i;
          lsb_d    = lsb_i;
          len_d    = len_i;
          div_d    = div_i;
          cs_sel_d = cs_sel_i;
          tx_d     = tx_data_i;
          edg_d    = '0;
          rxsh_d   = '0;
          mosi_d   = cpha_i ? 1'b0 : tx_data_i[first_pos];
`ifdef SPI_XFER_LOOPBACK_EN
          lpbk_d   = lpbk_i;
`endif
        end
      end
      SETUP, SHIFT: begin
        if (!tick) begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end else begin
          cnt_d = '0;
          if (!(state_q == SHIFT && last)) begin
            sck_d = ~sck_q;
            edg_d = edg_q + (LW+2)'(1);
            if (smp_edge) rxsh_d[smp_pos] = miso_s;
            if (!smp_edge && drv_ok) mosi_d = tx_q[drv_pos];
          end
        end
      end
      HOLD: begin
        if (!tick) begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end else begin
          cnt_d  = '0;
          done_d = 1'b1;
          rx_d   = rxsh_q;
          mosi_d = 1'b0;
          sck_d  = cpol_q;
        end
      end
      default: ;
    endcase
    // Abort drops the transfer without publishing any received bits.
    if (abort_i && busy) begin
      cnt_d  = '0;
      done_d = 1'b0;
      rx_d   = rx_q;
      mosi_d = 1'b0;
      sck_d  = cpol_q;
    end
  end

  always_comb begin
    busy_o    = busy;
    done_o    = done_q;
    sck_o     = sck_q;
    mosi_o    = mosi_q;
    rx_data_o = rx_q;
    cs_n_o    = '1;
    for (int i = 0; i < CS_NUM; i++) begin
      if (busy && cs_sel_q == CW'(i)) cs_n_o[i] = 1'b0;
    end
  end

endmodule

// File: doc/spi_xfer_engine.md
SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the maximum bits per transfer (8..64).
REQ-002 The block SHALL have parameter CS_NUM, default 4, giving the number of chip-select lines (1..8).
REQ-003 The block SHALL have parameter DIV_WIDTH, default 16, giving the width of the SCK divider value.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk_i  input  1  system clock, all logic on rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 start_i  input  1  start request, honoured only when busy_o=0.
REQ-008 abort_i  input  1  synchronous transfer abort.
REQ-009 cpol_i, cpha_i, lsb_i  input  1 each  SPI mode, bit order (1=LSB first).
REQ-010 len_i  input  $clog2(DATA_WIDTH)  transfer length minus one, in bits.
REQ-011 div_i  input  DIV_WIDTH  SCK half-period minus one, in clk_i cycles.
REQ-012 cs_sel_i  input  $clog2(CS_NUM) (min 1)  chip-select index.
REQ-013 tx_data_i  input  DATA_WIDTH  transmit word, right-aligned.
REQ-014 rx_data_o  output  DATA_WIDTH  received word, right-aligned, upper bits zero.
REQ-015 busy_o, done_o  output  1 each  transfer active; one-cycle completion pulse.
REQ-016 sck_o, mosi_o  output  1 each  SPI clock and data out.
REQ-017 cs_n_o  output  CS_NUM  active-low chip selects.
REQ-018 miso_i  input  1  SPI data in.

Function
REQ-019 States SHALL be IDLE, SETUP, SHIFT, HOLD; start_i in IDLE latches all config and tx_data_i, next state SETUP.
REQ-020 start_i while busy_o=1 SHALL be ignored; config input changes during a transfer SHALL have no effect.
REQ-021 busy_o SHALL be 1 in SETUP/SHIFT/HOLD; cs_n_o[cs_sel] SHALL be 0 in those states, all others 1; cs_sel>=CS_NUM asserts no CS but the transfer still runs.
REQ-022 Each of SETUP, HOLD and every SHIFT half-period SHALL last div_i+1 clk cycles; N=len_i+1 bits give 2N SCK edges; busy_o stays high exactly (2N+2)*(div_i+1) cycles.
REQ-023 sck_o SHALL rest at latched cpol in IDLE/SETUP/HOLD and toggle at each SHIFT half-period boundary.
REQ-024 CPHA=0: first bit driven on mosi_o at SETUP entry, miso_i sampled on leading edges, next bit driven on trailing edges; CPHA=1: bit driven on leading edges, sampled on trailing edges.
REQ-025 MSB-first transmits tx_data[N-1] first and places the last received bit at rx bit 0; LSB-first transmits bit 0 first and places the first received bit at rx bit 0.
REQ-026 On HOLD exit: state IDLE, cs_n_o all 1, done_o=1 for one cycle, rx_data_o updated in that same cycle and held until next done_o.
REQ-027 abort_i in any busy state SHALL return to IDLE next cycle, CS deasserted, sck_o=cpol, no done_o, rx_data_o unchanged; abort_i and start_i together in IDLE: start wins.
REQ-028 mosi_o SHALL be 0 in IDLE.

Reset
REQ-029 rst_i SHALL immediately force IDLE, busy_o=0, done_o=0, sck_o=0, mosi_o=0, cs_n_o all 1, rx_data_o=0, including mid-transfer.
REQ-030 After rst_i release, sck_o SHALL follow cpol_i from the next clk_i edge in IDLE.

Configuration
REQ-031 With SPI_XFER_LOOPBACK_EN defined, an input lpbk_i (1 bit) SHALL exist; when latched 1 the receive path samples internal mosi instead of miso_i.
REQ-032 Without SPI_XFER_LOOPBACK_EN, lpbk_i SHALL not exist and receive always samples miso_i.

Verification
REQ-033 Mode 0, MSB, len=7, div=1, tx=0xA5, miso looped to mosi externally -> sck 8 pulses, busy 36 cycles, done_o once, rx_data_o=0x000000A5.
REQ-034 Mode 3, LSB, len=15, div=0, tx=0x1234, miso tied 1 -> mosi sequence 0,0,1,0,1,1,0,0..., rx_data_o=0x0000FFFF, cs_n_o[2]=0 with cs_sel=2.
REQ-035 abort_i after 5 SCK edges -> IDLE next cycle, cs_n_o=4'hF, no done_o, rx_data_o unchanged.
REQ-036 start_i during busy with new tx -> ignored, first transfer completes unchanged.
REQ-037 rst_i mid SHIFT -> all outputs reset values same cycle, no done_o after release.
REQ-038 SPI_XFER_LOOPBACK_EN defined, lpbk_i=1, len=31, tx=0xDEADBEEF, miso tied 0 -> rx_data_o=0xDEADBEEF.
